cpu_run_monitor: RTL and testbench

Synthesizable run controller and trace recorder for the pipelined CPU. It generalises the fixed-duration simulation harness into a parametrised block.
- Sequences the CPU reset and counts run cycles.
- Records a ring buffer of NUM_PROBES probe words (pc, inst, ealu, malu, wdi, …) per cycle.
- Ends the run on timeout, PC stall, or abort, then exposes the trace for readout.
- Sits beside the CPU core in simulation and FPGA bring-up tops.

---
 rtl/run_monitor_pkg.sv | 19 +
 rtl/trace_ring_ram.sv | 28 ++
 rtl/cpu_run_monitor.sv | 162 ++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared definitions for the CPU run monitor: FSM states, done-reason codes
// and the probe channel that carries the program counter.
package run_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] RSN_NONE    = 2'd0;
   localparam logic [1:0] RSN_TIMEOUT = 2'd1;
   localparam logic [1:0] RSN_STALL   = 2'd2;
   localparam logic [1:0] RSN_ABORT   = 2'd3;

   localparam int PC_CH = 0;

endpackage

// File: rtl/trace_ring_ram.sv
// Simple dual-port trace RAM: one write port, one synchronous read port
// whose output register clears on clr.
module trace_ring_ram #(
   parameter int DEPTH = 16,
   parameter int DW    = 160,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (clr) rdata <= '0;
      else     rdata <= mem_q[raddr];
   end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller and trace recorder for the pipelined CPU.
// Optional probe signature enabled by defining RUN_MONITOR_SIGNATURE_EN.
module cpu_run_monitor
   import run_monitor_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int NUM_PROBES   = 5,
   parameter int TRACE_DEPTH  = 16,
   parameter int RESET_CYCLES = 2,
   parameter int MAX_CYCLES   = 84,
   parameter int STALL_LIMIT  = 8,
   parameter int CNT_W        = 16
) (
   input  logic                               clk,
   input  logic                               clr,
   input  logic                               start,
   input  logic                               abort,
   input  logic [NUM_PROBES*WIDTH-1:0]        probes,
   output logic                               cpu_clrn,
   output logic                               running,
   output logic                               done,
   output logic [1:0]                         done_reason,
   output logic [CNT_W-1:0]                   cycles,
   output logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_count,
   input  logic [$clog2(TRACE_DEPTH)-1:0]     rd_idx,
   output logic [NUM_PROBES*WIDTH-1:0]        rd_data,
   output logic [WIDTH-1:0]                   signature
);

   localparam int AW  = $clog2(TRACE_DEPTH);
   localparam int TCW = $clog2(TRACE_DEPTH+1);
   localparam int SW  = $clog2(STALL_LIMIT+1);
   localparam int RCW = $clog2(RESET_CYCLES+1);
   localparam int DW  = NUM_PROBES*WIDTH;

   state_e          state_q, state_d;
   logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [TCW-1:0]  tcount_q, tcount_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [SW-1:0]   stall_q, stall_d, stall_now;
   logic [1:0]      reason_q, reason_d;
   logic [WIDTH-1:0] pc, prev_pc_q;
   logic            pc_same, hit_stall, hit_tmo, enter_rst;
   logic [AW-1:0]   raddr;

   assign pc        = probes[PC_CH*WIDTH +: WIDTH];
   // cycles_q is zero only in the first RUN cycle, which always counts as a PC change
   assign pc_same   = (cycles_q != '0) && (pc == prev_pc_q);
   assign stall_now = pc_same ? stall_q + SW'(1) : '0;
   assign hit_stall = pc_same && (stall_now == SW'(STALL_LIMIT-1));
   assign hit_tmo   = (cycles_q == CNT_W'(MAX_CYCLES-1));
   assign enter_rst = start && (state_q == ST_IDLE || state_q == ST_DONE);

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cycles_d  = cycles_q;
      tcount_d  = tcount_q;
      wptr_d    = wptr_q;
      stall_d   = stall_q;
      reason_d  = reason_q;
      if (enter_rst) begin
         state_d   = ST_RESET;
         rst_cnt_d = '0;
         cycles_d  = '0;
         tcount_d  = '0;
         wptr_d    = '0;
         stall_d   = '0;
         reason_d  = RSN_NONE;
      end else begin
         unique case (state_q)
            ST_RESET: begin
               if (rst_cnt_q == RCW'(RESET_CYCLES-1)) state_d = ST_RUN;
               else                                   rst_cnt_d = rst_cnt_q + RCW'(1);
            end
            ST_RUN: begin
               wptr_d   = wptr_q + AW'(1);
               tcount_d = (tcount_q == TCW'(TRACE_DEPTH)) ? tcount_q : tcount_q + TCW'(1);
               stall_d  = stall_now;
               if (abort || hit_stall || hit_tmo) begin
                  state_d  = ST_DONE;
                  reason_d = abort ? RSN_ABORT : (hit_stall ? RSN_STALL : RSN_TIMEOUT);
               end else begin
                  cycles_d = cycles_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         rst_cnt_q <= '0;
         cycles_q  <= '0;
         tcount_q  <= '0;
         wptr_q    <= '0;
         stall_q   <= '0;
         reason_q  <= RSN_NONE;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cycles_q  <= cycles_d;
         tcount_q  <= tcount_d;
         wptr_q    <= wptr_d;
         stall_q   <= stall_d;
         reason_q  <= reason_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_RUN) prev_pc_q <= pc;
   end

   // Once the ring has wrapped, the oldest entry sits at the write pointer
   assign raddr = (tcount_q < TCW'(TRACE_DEPTH)) ? rd_idx : wptr_q + rd_idx;

   trace_ring_ram #(
      .DEPTH (TRACE_DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .clr   (clr),
      .we    (state_q == ST_RUN),
      .waddr (wptr_q),
      .wdata (probes),
      .raddr (raddr),
      .rdata (rd_data)
   );

`ifdef RUN_MONITOR_SIGNATURE_EN
   logic [WIDTH-1:0] sig_q, sig_d, probe_xor;

   always_comb begin
      probe_xor = '0;
      for (int k = 0; k < NUM_PROBES; k++) probe_xor = probe_xor ^ probes[k*WIDTH +: WIDTH];
      sig_d = sig_q;
      if (enter_rst)              sig_d = '0;
      else if (state_q == ST_RUN) sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ probe_xor;
   end

   always_ff @(posedge clk) begin
      if (clr) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

   assign cpu_clrn    = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign running     = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign done_reason = reason_q;
   assign cycles      = cycles_q;
   assign trace_count = tcount_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: run results and trace reads are
// queued at launch and checked by a monitor when the DUT presents them.
module tb_cpu_run_monitor;

   localparam int W  = 32;
   localparam int NP = 5;
   localparam int DW = NP*W;

   logic           clk = 0;
   logic           clr, start, abort;
   logic [DW-1:0]  probes;
   logic           cpu_clrn, running, done;
   logic [1:0]     done_reason;
   logic [15:0]    cycles;
   logic [4:0]     trace_count;
   logic [3:0]     rd_idx;
   logic [DW-1:0]  rd_data;
   logic [W-1:0]   signature;

   typedef struct {
      logic [1:0]  rsn;
      int          cyc;
      int          cnt;
      logic [31:0] sig;
   } run_exp_t;

   run_exp_t       exp_q[$];
   logic [DW-1:0]  rd_q[$];
   logic           rd_pend = 0;
   logic           rd_vld = 0;
   int             nvec = 0;
   int             nfail = 0;

   cpu_run_monitor dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .abort       (abort),
      .probes      (probes),
      .cpu_clrn    (cpu_clrn),
      .running     (running),
      .done        (done),
      .done_reason (done_reason),
      .cycles      (cycles),
      .trace_count (trace_count),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .signature   (signature)
   );

   always #2 clk = ~clk;

   always @(posedge clk) rd_vld <= rd_pend;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pc_of(input int mode, input int k);
      case (mode)
         0:       return 32'(4*k);
         1:       return (k < 10) ? 32'(4*k) : 32'h0000005C;
         2:       return 32'h100 + 32'(4*k);
         default: return (k < 76) ? 32'(4*k) : 32'h00001000;
      endcase
   endfunction

   function automatic logic [DW-1:0] mkp(input logic [31:0] pc);
      logic [DW-1:0] p;
      p = '0;
      for (int ch = 0; ch < NP; ch++) p[ch*W +: W] = pc ^ (32'(ch) * 32'h01010101);
      return p;
   endfunction

   function automatic logic [31:0] xorall(input logic [DW-1:0] p);
      logic [31:0] x;
      x = '0;
      for (int ch = 0; ch < NP; ch++) x = x ^ p[ch*W +: W];
      return x;
   endfunction

   // Monitor: compare run results on the rising edge of done and reads one cycle after issue
   initial begin
      logic     done_prev;
      run_exp_t e;
      done_prev = 0;
      forever begin
         @(negedge clk);
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_reason", done_reason, e.rsn);
               chk("cycles", cycles, e.cyc);
               chk("trace_count", trace_count, e.cnt);
               chk("signature", signature, e.sig);
            end
         end
         done_prev = done;
         if (rd_vld) begin
            if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
            else                  chk("rd_data", rd_data, rd_q.pop_front());
         end
      end
   end

   task automatic rd_chk(input int idx, input int mode, input int k);
      rd_idx  = 4'(idx);
      rd_pend = 1;
      rd_q.push_back(mkp(pc_of(mode, k)));
      @(negedge clk);
   endtask

   task automatic rd_end();
      rd_pend = 0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_clrn"}, cpu_clrn, 0);
      chk({nm, "_running"}, running, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_reason"}, done_reason, 0);
      chk({nm, "_cycles"}, cycles, 0);
      chk({nm, "_count"}, trace_count, 0);
      chk({nm, "_rd_data"}, rd_data, 0);
      chk({nm, "_sig"}, signature, 0);
   endtask

   // mode selects the PC pattern; mode 2 also holds start high through RUN
   task automatic do_run(input int mode, input int ab_at, input int clr_at,
                         input logic [1:0] e_rsn, input int e_cyc, input int e_cnt);
      logic [31:0]   sig;
      logic [DW-1:0] p;
      int            k;
      sig = '0;
      if (clr_at < 0) begin
`ifdef RUN_MONITOR_SIGNATURE_EN
         for (int j = 0; j <= e_cyc; j++) sig = {sig[30:0], sig[31]} ^ xorall(mkp(pc_of(mode, j)));
`endif
         exp_q.push_back('{e_rsn, e_cyc, e_cnt, sig});
      end
      start = 1;
      @(negedge clk);
      start = 0;
      chk("reset_clrn_a", cpu_clrn, 0);
      chk("reset_cleared", {done_reason, cycles, 11'(trace_count)}, 0);
      @(negedge clk);
      chk("reset_clrn_b", cpu_clrn, 0);
      @(negedge clk);
      chk("run_entry", {cpu_clrn, running, done}, 3'b110);
      k = 0;
      while (!done && k < 200) begin
         p      = mkp(pc_of(mode, k));
         probes = p;
         abort  = (k == ab_at);
         start  = (mode == 2);
         if (k == clr_at) clr = 1;
         @(negedge clk);
         if (clr) begin
            clr   = 0;
            abort = 0;
            start = 0;
            chk_zero("midrun_clr");
            return;
         end
         k++;
      end
      abort = 0;
      start = 0;
      if (!done) chk("run_budget", 0, 1);
   endtask

   initial begin
      clr    = 1;
      start  = 0;
      abort  = 0;
      probes = '0;
      rd_idx = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      clr = 0;
      @(negedge clk);
      chk("idle_clrn", {cpu_clrn, running}, 0);

      // Timeout with PC += 4
      do_run(0, -1, -1, 2'd1, 83, 16);
      abort = 1;
      repeat (3) @(negedge clk);
      abort = 0;
      chk("frozen_cycles", cycles, 83);
      chk("frozen_done", {done, cpu_clrn, done_reason}, 4'b1101);
      rd_chk(0, 0, 68);
      rd_chk(15, 0, 83);
      rd_chk(7, 0, 75);
      rd_end();

      // PC stuck at 0x5C from cycle 10
      do_run(1, -1, -1, 2'd2, 17, 16);
      rd_chk(0, 1, 2);
      rd_chk(15, 1, 17);
      rd_end();

      // Short aborted run, start held high during RUN
      do_run(2, 5, -1, 2'd3, 5, 6);
      for (int i = 0; i <= 5; i++) rd_chk(i, 2, i);
      rd_end();

      // Abort, stall and timeout on the same cycle, then stall with timeout
      do_run(3, 83, -1, 2'd3, 83, 16);
      do_run(3, -1, -1, 2'd2, 83, 16);

      // clr mid-run, then a fresh run from IDLE
      do_run(0, -1, 20, 2'd0, 0, 0);
      do_run(2, 3, -1, 2'd3, 3, 4);
      rd_chk(3, 2, 3);
      rd_end();

      repeat (2) @(negedge clk);
      chk("sb_drain", {exp_q.size(), rd_q.size()}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
